// File: rtl/fir_pkg.sv
// Shared width constants and word types for the FIR filter chain.
// Imported by the filter core and by the output conditioner.
package fir_pkg;

  localparam int FIR_IN_WIDTH   = 12;
  localparam int FIR_OUT_WIDTH  = 28;
  localparam int FIR_COEF_WIDTH = 16;
  localparam int COND_OUT_WIDTH = 16;

  typedef logic signed [COND_OUT_WIDTH-1:0] cond_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy level output.
// Ports: clk, rst_n (sync, active-low), push/wdata, pop/rdata, level, full, empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fir_output_conditioner.sv
// Decimate, round, shift and saturate FIR samples into a ready/valid FIFO.
// Ports: i_clk, i_reset (sync active-low), sample in, stream out, level, sticky flags.
module fir_output_conditioner
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = FIR_OUT_WIDTH,
  parameter int OUT_WIDTH  = COND_OUT_WIDTH,
  parameter int SHIFT      = 12,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_sample_en,
  input  logic signed [IN_WIDTH-1:0]          i_fir_data,
  output logic signed [OUT_WIDTH-1:0]         o_data,
  output logic                                o_data_valid,
  input  logic                                i_data_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_fifo_level,
  output logic                                o_sat_sticky,
  output logic                                o_drop_sticky,
  input  logic                                i_clear_flags
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int XW = IN_WIDTH + 1;

  localparam logic signed [XW-1:0] HALF = XW'(1) << (SHIFT - 1);
  localparam logic signed [XW-1:0] SMAX = (XW'(1) << (OUT_WIDTH - 1)) - XW'(1);
  localparam logic signed [XW-1:0] SMIN = -(XW'(1) << (OUT_WIDTH - 1));

  logic [CW-1:0]          cnt;
  logic                   keep;
  logic signed [XW-1:0]   sum;
  logic signed [XW-1:0]   r1;
  logic                   v1;
  logic                   hi;
  logic                   lo;
  logic [OUT_WIDTH-1:0]   sat_word;
  logic [OUT_WIDTH-1:0]   w2;
  logic                   v2;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   drop;

  assign keep = i_sample_en && (cnt == '0);

  // One extra bit keeps the rounding add from wrapping.
  assign sum = $signed({i_fir_data[IN_WIDTH-1], i_fir_data}) + HALF;

  assign hi = (r1 > SMAX);
  assign lo = (r1 < SMIN);

  always_comb begin
    sat_word = r1[OUT_WIDTH-1:0];
    unique case (1'b1)
      hi:      sat_word = SMAX[OUT_WIDTH-1:0];
      lo:      sat_word = SMIN[OUT_WIDTH-1:0];
      default: sat_word = r1[OUT_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt <= '0;
      v1  <= 1'b0;
      v2  <= 1'b0;
    end else begin
      if (i_sample_en)
        cnt <= (cnt == CW'(DECIM - 1)) ? '0 : cnt + 1'b1;
      v1 <= keep;
      v2 <= v1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (keep) r1 <= sum >>> SHIFT;
    if (v1)   w2 <= sat_word;
  end

  assign o_data_valid = !empty;
  assign pop          = o_data_valid && i_data_ready;
  assign drop         = v2 && full && !pop;

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_sat_sticky  <= 1'b0;
      o_drop_sticky <= 1'b0;
    end else begin
      if (v1 && (hi || lo))  o_sat_sticky <= 1'b1;
      else if (i_clear_flags) o_sat_sticky <= 1'b0;
      if (drop)               o_drop_sticky <= 1'b1;
      else if (i_clear_flags) o_drop_sticky <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset),
    .push  (v2),
    .wdata (w2),
    .pop   (pop),
    .rdata (o_data),
    .level (o_fifo_level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_fir_output_conditioner.sv
// Directed self-checking bench for fir_output_conditioner.
// Two instances: DECIM=1 (dut1) and DECIM=4 (dut4).
module tb_fir_output_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst1, en1, rdy1, clr1;
  logic signed [27:0] d1;
  logic signed [15:0] q1;
  logic               v1, sat1, drop1;
  logic [3:0]         lvl1;

  logic               rst4, en4, rdy4, clr4;
  logic signed [27:0] d4;
  logic signed [15:0] q4;
  logic               v4, sat4, drop4;
  logic [3:0]         lvl4;

  int total = 0;
  int bad   = 0;

  fir_output_conditioner #(.DECIM(1)) dut1 (
    .i_clk(clk), .i_reset(rst1), .i_sample_en(en1), .i_fir_data(d1),
    .o_data(q1), .o_data_valid(v1), .i_data_ready(rdy1),
    .o_fifo_level(lvl1), .o_sat_sticky(sat1), .o_drop_sticky(drop1),
    .i_clear_flags(clr1)
  );

  fir_output_conditioner #(.DECIM(4)) dut4 (
    .i_clk(clk), .i_reset(rst4), .i_sample_en(en4), .i_fir_data(d4),
    .o_data(q4), .o_data_valid(v4), .i_data_ready(rdy4),
    .o_fifo_level(lvl4), .o_sat_sticky(sat4), .o_drop_sticky(drop4),
    .i_clear_flags(clr4)
  );

  task automatic test_reset();
    rst1 = 0; rst4 = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (v1 !== 0 || lvl1 !== 0 || sat1 !== 0 || drop1 !== 0) begin
      bad++;
      $display("FAIL reset1 got v=%0b l=%0d s=%0b d=%0b exp 0 0 0 0", v1, lvl1, sat1, drop1);
    end
    total++;
    if (v4 !== 0 || lvl4 !== 0 || sat4 !== 0 || drop4 !== 0) begin
      bad++;
      $display("FAIL reset4 got v=%0b l=%0d s=%0b d=%0b exp 0 0 0 0", v4, lvl4, sat4, drop4);
    end
    rst1 = 1; rst4 = 1;
  endtask

  task automatic test_decim1();
    int xs[4] = '{2048, -2048, 6144, -6144};
    int es[4] = '{1, 0, 2, -1};
    rdy1 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); en1 = 1; d1 = 28'(xs[i]);
      @(negedge clk); en1 = 0;
      total++;
      if (v1 !== 0) begin
        bad++; $display("FAIL lat_e0[%0d] got v=%0b exp 0", i, v1);
      end
      @(negedge clk);
      total++;
      if (v1 !== 0) begin
        bad++; $display("FAIL lat_e1[%0d] got v=%0b exp 0", i, v1);
      end
      @(negedge clk);
      total++;
      if (v1 !== 1 || q1 !== 16'(es[i])) begin
        bad++;
        $display("FAIL round[%0d] got v=%0b q=%0d exp v=1 q=%0d", i, v1, q1, es[i]);
      end
      @(negedge clk);
      total++;
      if (v1 !== 0) begin
        bad++; $display("FAIL popped[%0d] got v=%0b exp 0", i, v1);
      end
    end
  endtask

  task automatic test_saturation();
    rdy1 = 1;
    @(negedge clk); en1 = 1; d1 = 28'h7FFFFFF;
    @(negedge clk); en1 = 0;
    total++;
    if (sat1 !== 0) begin
      bad++; $display("FAIL sat_early got %0b exp 0", sat1);
    end
    @(negedge clk);
    total++;
    if (sat1 !== 1) begin
      bad++; $display("FAIL sat_set got %0b exp 1", sat1);
    end
    @(negedge clk);
    total++;
    if (v1 !== 1 || q1 !== 16'sd32767) begin
      bad++; $display("FAIL sat_pos got v=%0b q=%0d exp v=1 q=32767", v1, q1);
    end
    @(negedge clk); en1 = 1; d1 = -28'sd134217728;
    @(negedge clk); en1 = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (v1 !== 1 || q1 !== -16'sd32768 || sat1 !== 1) begin
      bad++;
      $display("FAIL sat_neg got v=%0b q=%0d s=%0b exp v=1 q=-32768 s=1", v1, q1, sat1);
    end
    @(negedge clk); clr1 = 1;
    @(negedge clk); clr1 = 0;
    total++;
    if (sat1 !== 0) begin
      bad++; $display("FAIL sat_clear got %0b exp 0", sat1);
    end
    // clip lands on the same edge as the clear
    @(negedge clk); en1 = 1; d1 = 28'h7FFFFFF;
    @(negedge clk); en1 = 0; clr1 = 1;
    @(negedge clk); clr1 = 0;
    total++;
    if (sat1 !== 1) begin
      bad++; $display("FAIL sat_set_wins got %0b exp 1", sat1);
    end
    @(negedge clk);
    @(negedge clk); clr1 = 1;
    @(negedge clk); clr1 = 0;
    total++;
    if (sat1 !== 0 || drop1 !== 0) begin
      bad++; $display("FAIL flags_idle got s=%0b d=%0b exp 0 0", sat1, drop1);
    end
  endtask

  task automatic test_decim4();
    int gap[8] = '{0, 1, 2, 3, 0, 3, 1, 2};
    int got[4];
    int n = 0;
    int k = 0;
    int w = 0;
    rdy4 = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (v4) begin
        if (n < 4) got[n] = int'(q4);
        n++;
      end
      if (k < 8 && w == 0) begin
        en4 = 1; d4 = 28'((k + 1) * 4096);
        w = gap[k]; k++;
      end else begin
        en4 = 0;
        if (w > 0) w--;
      end
    end
    en4 = 0;
    total++;
    if (n !== 2) begin
      bad++; $display("FAIL decim_count got %0d exp 2", n);
    end
    total++;
    if (n < 2 || got[0] !== 1 || got[1] !== 5) begin
      bad++;
      $display("FAIL decim_vals got %0d,%0d exp 1,5", got[0], got[1]);
    end
  endtask

  task automatic test_back_pressure();
    rdy1 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); en1 = 1; d1 = 28'(k * 4096);
    end
    @(negedge clk); en1 = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (lvl1 !== 8 || drop1 !== 1 || v1 !== 1) begin
      bad++;
      $display("FAIL bp_full got l=%0d d=%0b v=%0b exp 8 1 1", lvl1, drop1, v1);
    end
    rdy1 = 1;
    total++;
    if (q1 !== 16'sd1) begin
      bad++; $display("FAIL bp_q[1] got %0d exp 1", q1);
    end
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      total++;
      if (v1 !== 1 || q1 !== 16'(k)) begin
        bad++; $display("FAIL bp_q[%0d] got v=%0b q=%0d exp 1 %0d", k, v1, q1, k);
      end
    end
    @(negedge clk);
    total++;
    if (v1 !== 0 || lvl1 !== 0) begin
      bad++; $display("FAIL bp_empty got v=%0b l=%0d exp 0 0", v1, lvl1);
    end
    clr1 = 1;
    @(negedge clk); clr1 = 0;
    total++;
    if (drop1 !== 0) begin
      bad++; $display("FAIL drop_clear got %0b exp 0", drop1);
    end
  endtask

  task automatic test_full_pop();
    rdy1 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); en1 = 1; d1 = 28'(k * 4096);
    end
    @(negedge clk); en1 = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (lvl1 !== 8) begin
      bad++; $display("FAIL fp_fill got %0d exp 8", lvl1);
    end
    en1 = 1; d1 = 28'(9 * 4096);
    @(negedge clk); en1 = 0;
    @(negedge clk); rdy1 = 1;
    @(negedge clk);
    total++;
    if (lvl1 !== 8 || drop1 !== 0 || q1 !== 16'sd2) begin
      bad++;
      $display("FAIL fp_same_edge got l=%0d d=%0b q=%0d exp 8 0 2", lvl1, drop1, q1);
    end
    for (int k = 3; k <= 9; k++) begin
      @(negedge clk);
      total++;
      if (v1 !== 1 || q1 !== 16'(k)) begin
        bad++; $display("FAIL fp_q[%0d] got v=%0b q=%0d exp 1 %0d", k, v1, q1, k);
      end
    end
    @(negedge clk);
    total++;
    if (v1 !== 0 || lvl1 !== 0) begin
      bad++; $display("FAIL fp_empty got v=%0b l=%0d exp 0 0", v1, lvl1);
    end
  endtask

  task automatic test_reset_mid();
    rdy1 = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) begin
        total++;
        if (lvl1 !== 5) begin
          bad++; $display("FAIL rm_pre got %0d exp 5", lvl1);
        end
        rst1 = 0;
      end
      en1 = 1; d1 = 28'(i * 4096);
    end
    @(negedge clk); rst1 = 1; en1 = 0;
    total++;
    if (v1 !== 0 || lvl1 !== 0) begin
      bad++; $display("FAIL rm_clear got v=%0b l=%0d exp 0 0", v1, lvl1);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (v1 !== 0 || lvl1 !== 0) begin
      bad++; $display("FAIL rm_flight got v=%0b l=%0d exp 0 0", v1, lvl1);
    end
    rdy1 = 1; en1 = 1; d1 = 28'(3 * 4096);
    @(negedge clk); en1 = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (v1 !== 1 || q1 !== 16'sd3) begin
      bad++; $display("FAIL rm_first got v=%0b q=%0d exp 1 3", v1, q1);
    end
    // DECIM=4: leave the counter mid-cycle, then reset it
    rdy4 = 1;
    @(negedge clk); en4 = 1; d4 = 28'(1 * 4096);
    @(negedge clk); d4 = 28'(2 * 4096);
    @(negedge clk); en4 = 0;
    repeat (5) @(negedge clk);
    rst4 = 0;
    @(negedge clk); rst4 = 1;
    total++;
    if (v4 !== 0 || lvl4 !== 0) begin
      bad++; $display("FAIL rm4_clear got v=%0b l=%0d exp 0 0", v4, lvl4);
    end
    en4 = 1; d4 = 28'(7 * 4096);
    @(negedge clk); en4 = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (v4 !== 1 || q4 !== 16'sd7) begin
      bad++; $display("FAIL rm4_first got v=%0b q=%0d exp 1 7", v4, q4);
    end
  endtask

  initial begin
    rst1 = 0; en1 = 0; rdy1 = 0; clr1 = 0; d1 = '0;
    rst4 = 0; en4 = 0; rdy4 = 0; clr4 = 0; d4 = '0;
    test_reset();
    test_decim1();
    test_saturation();
    test_decim4();
    test_back_pressure();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
